// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_pkg
// Description : Shared constants and a reference add function for the
//               registered ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;

  // Reference {carry, sum} for a width-bit add; operands must be zero-extended
  // above 'width'. Carry lands at bit 'width' of the returned vector.
  function automatic logic [64:0] fa_ref(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic        c,
                                         input int unsigned width);
    logic [64:0] full;
    logic [64:0] mask;
    full = {1'b0, a} + {1'b0, b} + {64'd0, c};
    mask = (65'd1 << width) - 65'd1;
    return (full & mask) | ({64'd0, full[width]} << width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_cell
// Description : Combinational 1-bit full adder. Pure gate equations so that
//               unknown inputs propagate exactly as the logic dictates.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (b & ci) | (a & ci);

endmodule
`default_nettype wire

// File: rtl/full_adder_sync.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_sync
// Description : WIDTH-bit ripple-carry adder with carry-in/carry-out and a
//               single output register stage (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_sync
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0]   w_k;
  logic [WIDTH-1:0] w_s;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_out_valid;

  assign w_k[0] = c;

  // Ripple chain: each cell's carry-out feeds the next cell's carry-in.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
        .a  (a[i]),
        .b  (b[i]),
        .ci (w_k[i]),
        .s  (w_s[i]),
        .co (w_k[i+1])
      );
    end
  endgenerate

  // Output register: capture on valid input, hold otherwise; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_s;
        r_carry <= w_k[WIDTH];
      end
    end
  end

  assign sum       = r_sum;
  assign carry     = r_carry;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_full_adder_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder_sync
// Description : Directed self-checking bench for full_adder_sync at WIDTH 1,
//               8 and 16 sharing one clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder_sync;
  import full_adder_pkg::*;

  logic clk;
  logic rst;

  logic       iv1, a1, b1, c1, ov1, s1, k1;
  logic       iv8, c8, ov8, k8;
  logic [7:0] a8, b8, s8;
  logic        iv16, c16, ov16, k16;
  logic [15:0] a16, b16, s16;

  int n_cmp;
  int n_err;

  full_adder_sync #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .c(c1),
    .out_valid(ov1), .sum(s1), .carry(k1)
  );

  full_adder_sync #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .c(c8),
    .out_valid(ov8), .sum(s8), .carry(k8)
  );

  full_adder_sync #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .a(a16), .b(b16), .c(c16),
    .out_valid(ov16), .sum(s16), .carry(k16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  exp_s1;
    logic [7:0]  exp_k1;
    logic [2:0]  v;
    logic        xprobe;
    logic        four_state;
    logic [15:0] ra, rb;
    logic        rc;
    logic [64:0] exp;

    n_cmp = 0;
    n_err = 0;
    xprobe = 1'bx;
    four_state = (xprobe === 1'bx);

    rst = 1'b1;
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; c8 = 1'b0;
    iv16 = 1'b0; a16 = 16'd0; b16 = 16'd0; c16 = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_w1",  {62'd0, ov1, k1, s1}, 65'd0);
    chk("rst_w8",  {55'd0, ov8, k8, s8}, 65'd0);
    chk("rst_w16", {47'd0, ov16, k16, s16}, 65'd0);

    rst = 1'b0;

    // Exhaustive 1-bit truth table, index = {a,b,c}
    exp_s1 = 8'b1001_0110;
    exp_k1 = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      iv1 = 1'b1; a1 = v[2]; b1 = v[1]; c1 = v[0];
      tick();
      chk($sformatf("w1_abc%0d", i), {62'd0, ov1, k1, s1},
          {62'd0, 1'b1, exp_k1[i], exp_s1[i]});
    end

    // Unknown propagation through the gate equations (4-state simulators only)
    if (four_state) begin
      a1 = 1'bx; b1 = 1'bx; c1 = 1'bx; tick();
      chk("x_xxx", {63'd0, k1, s1}, {63'd0, 1'bx, 1'bx});
      a1 = 1'bx; b1 = 1'bx; c1 = 1'b0; tick();
      chk("x_xx0", {63'd0, k1, s1}, {63'd0, 1'bx, 1'bx});
      a1 = 1'bx; b1 = 1'b0; c1 = 1'b0; tick();
      chk("x_x00", {63'd0, k1, s1}, {63'd0, 1'b0, 1'bx});
      a1 = 1'b0; b1 = 1'b0; c1 = 1'bx; tick();
      chk("x_00x", {63'd0, k1, s1}, {63'd0, 1'b0, 1'bx});
      a1 = 1'b0; b1 = 1'bx; c1 = 1'bx; tick();
      chk("x_0xx", {63'd0, k1, s1}, {63'd0, 1'bx, 1'bx});
      a1 = 1'b0; b1 = 1'bz; c1 = 1'b0; tick();
      chk("x_0z0", {63'd0, k1, s1}, {63'd0, 1'b0, 1'bx});
    end
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;

    // Wrap-around at WIDTH=8
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    tick();
    chk("wrap_ff", {55'd0, ov8, k8, s8}, {55'd0, 1'b1, 1'b1, 8'hFF});
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    tick();
    chk("wrap_80", {55'd0, ov8, k8, s8}, {55'd0, 1'b1, 1'b1, 8'h00});

    // Hold while in_valid is low
    a8 = 8'd3; b8 = 8'd4; c8 = 1'b0;
    tick();
    chk("hold_load", {55'd0, ov8, k8, s8}, {55'd0, 1'b1, 1'b0, 8'd7});
    iv8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'hA0 + 8'(i); b8 = 8'h77; c8 = i[0];
      tick();
      chk($sformatf("hold_%0d", i), {55'd0, ov8, k8, s8}, {55'd0, 1'b0, 1'b0, 8'd7});
    end

    // Reset beats a simultaneous valid input
    rst = 1'b1; iv8 = 1'b1; a8 = 8'd5; b8 = 8'd5; c8 = 1'b0;
    tick();
    chk("rst_prio", {55'd0, ov8, k8, s8}, 65'd0);
    rst = 1'b0; a8 = 8'd1; b8 = 8'd1; c8 = 1'b1;
    tick();
    chk("post_rst", {55'd0, ov8, k8, s8}, {55'd0, 1'b1, 1'b0, 8'd3});
    iv8 = 1'b0;

    // Back-to-back random vectors at WIDTH=16
    iv16 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i == 0) begin ra = 16'hFFFF; rb = 16'h0000; rc = 1'b1; end
      a16 = ra; b16 = rb; c16 = rc;
      exp = fa_ref({48'd0, ra}, {48'd0, rb}, rc, 16);
      tick();
      chk($sformatf("rand_%0d", i), {47'd0, ov16, k16, s16}, {47'd0, 1'b1, exp[16:0]});
    end
    iv16 = 1'b0;
    tick();
    chk("rand_ov_drop", {64'd0, ov16}, 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
